// File: rtl/bound_flasher_gen.sv
// Parametrised LED bar flasher: thermometer bar driven through a six-phase
// bounded up/down sequence, paced by step_en, with flick kickback at HI1/HI2.
module bound_flasher_gen #(
  parameter  int N_LED = 16,
  parameter  int HI1   = 6,
  parameter  int LO2   = 5,
  parameter  int HI2   = 11,
  localparam int LW    = $clog2(N_LED + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic             flick,
  input  logic             clr,
  output logic [N_LED-1:0] led,
  output logic [LW-1:0]    lvl_o,
  output logic             busy,
  output logic             done
);

  if (!(N_LED >= 4 && LO2 > 0 && LO2 < HI1 && HI1 < HI2 && HI2 < N_LED)) begin : g_bad_params
    $error("bound_flasher_gen: require 0 < LO2 < HI1 < HI2 < N_LED and N_LED >= 4");
  end

  localparam logic [LW-1:0] ONE   = LW'(1);
  localparam logic [LW-1:0] HI1_L = LW'(HI1);
  localparam logic [LW-1:0] LO2_L = LW'(LO2);
  localparam logic [LW-1:0] HI2_L = LW'(HI2);
  localparam logic [LW-1:0] TOP_L = LW'(N_LED);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP_A = 3'd1,
    DN_A = 3'd2,
    UP_B = 3'd3,
    DN_B = 3'd4,
    UP_C = 3'd5,
    DN_C = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [N_LED-1:0]  led_q;
  logic              busy_q;
  logic              done_q, done_d;
  logic              kick;

  function automatic logic [N_LED-1:0] therm(input logic [LW-1:0] l);
    logic [N_LED-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      t[i] = (LW'(i) < l);
    end
    return t;
  endfunction

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    done_d  = 1'b0;
    kick    = flick && (lvl_q == HI1_L || lvl_q == HI2_L);

    case (state_q)
      IDLE: begin
        if (step_en && flick) begin
          lvl_d   = ONE;
          state_d = UP_A;
        end
      end
      UP_A: begin
        if (step_en) begin
          if (lvl_q == HI1_L) begin
            lvl_d   = lvl_q - ONE;
            state_d = DN_A;
          end else begin
            lvl_d = lvl_q + ONE;
          end
        end
      end
      DN_A: begin
        if (step_en) begin
          if (lvl_q == '0) begin
            lvl_d   = ONE;
            state_d = UP_B;
          end else begin
            lvl_d = lvl_q - ONE;
          end
        end
      end
      UP_B: begin
        if (step_en) begin
          if (kick) begin
            lvl_d   = lvl_q - ONE;
            state_d = DN_A;
          end else if (lvl_q == HI2_L) begin
            lvl_d   = lvl_q - ONE;
            state_d = DN_B;
          end else begin
            lvl_d = lvl_q + ONE;
          end
        end
      end
      DN_B: begin
        if (step_en) begin
          if (lvl_q == LO2_L) begin
            lvl_d   = lvl_q + ONE;
            state_d = UP_C;
          end else begin
            lvl_d = lvl_q - ONE;
          end
        end
      end
      UP_C: begin
        // The top of the bar wins over a kickback request.
        if (step_en) begin
          if (lvl_q == TOP_L) begin
            lvl_d   = lvl_q - ONE;
            state_d = DN_C;
          end else if (kick) begin
            lvl_d   = lvl_q - ONE;
            state_d = DN_B;
          end else begin
            lvl_d = lvl_q + ONE;
          end
        end
      end
      DN_C: begin
        if (step_en) begin
          if (lvl_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            lvl_d = lvl_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        lvl_d   = '0;
      end
    endcase

    if (clr) begin
      state_d = IDLE;
      lvl_d   = '0;
      done_d  = 1'b0;
    end
  end

  // led/busy are registered from the next-state values so they stay aligned with lvl_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      led_q   <= therm(lvl_d);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign led   = led_q;
  assign lvl_o = lvl_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Directed bench for bound_flasher_gen: default-parameter DUT plus a small
// N_LED=8 instance sharing the same stimulus.
module tb_bound_flasher_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_en = 1'b0;
  logic        flick = 1'b0;
  logic        clr = 1'b0;

  logic [15:0] led;
  logic [4:0]  lvl_o;
  logic        busy, done;

  logic [7:0]  led2;
  logic [3:0]  lvl2;
  logic        busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bound_flasher_gen dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .flick(flick), .clr(clr),
    .led(led), .lvl_o(lvl_o), .busy(busy), .done(done)
  );

  bound_flasher_gen #(.N_LED(8), .HI1(3), .LO2(2), .HI2(5)) dut_small (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .flick(flick), .clr(clr),
    .led(led2), .lvl_o(lvl2), .busy(busy2), .done(done2)
  );

  // Closed-form level after step s of an uninterrupted sequence.
  function automatic int exp_lvl(input int s, input int n, input int h1, input int l2, input int h2);
    int a, b, c, d, e;
    a = 2 * h1;
    b = a + h2;
    c = b + h2 - l2;
    d = c + n - l2;
    e = d + n;
    if (s <= 0) return 0;
    if (s <= h1) return s;
    if (s <= a) return a - s;
    if (s <= b) return s - a;
    if (s <= c) return h2 - (s - b);
    if (s <= d) return l2 + (s - c);
    if (s <= e) return n - (s - d);
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_main(input string tag, input int e_lvl, input bit e_busy, input bit e_done);
    logic [31:0] e_led;
    e_led = (32'd1 << e_lvl) - 32'd1;
    chk({tag, "_lvl"}, {27'd0, lvl_o}, e_lvl);
    chk({tag, "_led"}, {16'd0, led}, e_led);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
  endtask

  task automatic tick(input logic en, input logic fl);
    step_en = en;
    flick   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    step_en = 1'b0;
    flick   = 1'b0;
    clr     = 1'b0;
    rst_n   = 1'b0;
    #3;
    chk_main("reset", 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;

    // Full trace, step_en always high, flick on step 1 only
    do_reset();
    for (int k = 1; k <= 58; k++) begin
      tick(1'b1, k == 1);
      chk_main($sformatf("trace_s%0d", k), exp_lvl(k, 16, 6, 5, 11), k <= 56, k == 57);
    end

    // Same trace with step_en 1-in-4; flick on disabled cycles must be ignored
    do_reset();
    for (int k = 1; k <= 58; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick(1'b0, k == 1);
        chk_main($sformatf("pace_hold_s%0d", k), exp_lvl(k - 1, 16, 6, 5, 11),
                 (k - 1) >= 1 && (k - 1) <= 56, 1'b0);
      end
      tick(1'b1, k == 1);
      chk_main($sformatf("pace_s%0d", k), exp_lvl(k, 16, 6, 5, 11), k <= 56, k == 57);
    end

    // Kickback in UP_B at HI1 and HI2
    do_reset();
    tick(1'b1, 1'b1);
    run(17);
    chk_main("upb_at6", 6, 1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_main("upb_kick6", 5, 1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_main("dna_flick_ignored", 4, 1'b1, 1'b0);
    run(4);
    chk_main("dna_floor", 0, 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk_main("upb_again", 1, 1'b1, 1'b0);
    run(10);
    chk_main("upb_at11", 11, 1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_main("upb_kick11", 10, 1'b1, 1'b0);
    run(10);
    chk_main("dna_floor2", 0, 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk_main("upb_third", 1, 1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_main("upb_flick_ignored", 2, 1'b1, 1'b0);

    // Kickback in UP_C at HI2; top beats flick; restart with flick held
    do_reset();
    tick(1'b1, 1'b1);
    run(34);
    chk_main("upc_at11", 11, 1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_main("upc_kick11", 10, 1'b1, 1'b0);
    run(5);
    chk_main("dnb_floor", 5, 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk_main("upc_again", 6, 1'b1, 1'b0);
    run(10);
    chk_main("upc_top", 16, 1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_main("upc_top_flick", 15, 1'b1, 1'b0);
    run(11);
    chk_main("dnc_past_lo2", 4, 1'b1, 1'b0);
    run(4);
    chk_main("dnc_floor", 0, 1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_main("dnc_done", 0, 1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk_main("restart_held", 1, 1'b1, 1'b0);

    // Synchronous clear overriding step_en/flick at lvl 9
    do_reset();
    tick(1'b1, 1'b1);
    run(20);
    chk_main("pre_clr", 9, 1'b1, 1'b0);
    clr = 1'b1;
    tick(1'b1, 1'b1);
    chk_main("clr", 0, 1'b0, 1'b0);
    clr = 1'b0;
    tick(1'b1, 1'b0);
    chk_main("post_clr", 0, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk_main("post_clr2", 0, 1'b0, 1'b0);

    // Asynchronous reset mid-UP_C
    do_reset();
    tick(1'b1, 1'b1);
    run(34);
    chk_main("pre_rst", 11, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("async_rst", 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(3);
    chk_main("after_rst", 0, 1'b0, 1'b0);

    // Small-parameter instance full trace (N_LED=8, HI1=3, LO2=2, HI2=5)
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      tick(1'b1, k == 1);
      e = exp_lvl(k, 8, 3, 2, 5);
      chk($sformatf("small_s%0d_lvl", k), {28'd0, lvl2}, e);
      chk($sformatf("small_s%0d_led", k), {24'd0, led2}, ((32'd1 << e) - 32'd1) & 32'hFF);
      chk($sformatf("small_s%0d_busy", k), {31'd0, busy2}, {31'd0, k <= 28});
      chk($sformatf("small_s%0d_done", k), {31'd0, done2}, {31'd0, k == 29});
      if (k == 20) chk("small_peak", {28'd0, lvl2}, 32'd8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
